// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit for the RV32I core. It samples the program counter,
// issues one word read to instruction memory (req/ack), holds the returned
// word for decode (valid/ready) and pulses the PC load strobe on handoff so
// the PC advances by one word.
//
// Handshakes:
//   memory side : mem_req is held high with a stable mem_addr until a cycle
//                 with mem_ack high; mem_rdata is taken in that same cycle.
//   decode side : instr/instr_valid stay stable until a cycle with
//                 instr_ready high (the handoff); flush in that cycle cancels
//                 the handoff.
//
// Ports:
//   clk, clr            clock (rising edge), asynchronous active-low reset
//   fetch_en            allows a new fetch to start from IDLE
//   pc_val[31:0]        current PC
//   flush               redirect; discards in-flight or held instruction
//   mem_req, mem_addr   memory read request and word address
//   mem_ack, mem_rdata  memory response
//   instr, instr_valid  held instruction to decode
//   instr_ready         decode accepts instr
//   pc_load             one-cycle PC load strobe (combinational)
//   fetch_err           sticky error flag
//   err_code[1:0]       01 = misaligned PC, 10 = memory timeout
//
// Configuration:
//   INSTR_FETCH_TIMEOUT_EN  when defined, a request that waits TIMEOUT_CYCLES
//                           cycles without ack aborts into ERR with code 10.
//                           Otherwise REQ waits for ack indefinitely.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        fetch_en,
  input  logic [31:0] pc_val,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_load,
  output logic        fetch_err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // state is kept as a named enum so it is visible by name in waveforms
  // and to bound checkers.
  state_t state;

  // Set when a flush arrives while a memory read is outstanding; the bus
  // transaction cannot be cancelled, so its data is discarded on ack.
  logic drop;

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
`endif

  // Handoff strobe; flush in the same cycle wins because the branch path
  // loads the PC itself.
  assign pc_load = instr_valid & instr_ready & ~flush;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      drop        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      err_code    <= 2'b00;
`ifdef INSTR_FETCH_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en && !flush) begin
            if (pc_val[1:0] != 2'b00) begin
              state     <= ERR;
              fetch_err <= 1'b1;
              err_code  <= 2'b01;
            end else begin
              mem_addr <= pc_val;
              mem_req  <= 1'b1;
              state    <= REQ;
`ifdef INSTR_FETCH_TIMEOUT_EN
              tcnt     <= '0;
`endif
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
            tcnt    <= '0;
`endif
            // A flush now or earlier in this request makes the data stale.
            if (drop || flush) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              instr       <= mem_rdata;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else begin
            if (flush) drop <= 1'b1;
`ifdef INSTR_FETCH_TIMEOUT_EN
            // This no-ack cycle brings the count to TIMEOUT_CYCLES.
            if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
              mem_req   <= 1'b0;
              drop      <= 1'b0;
              fetch_err <= 1'b1;
              err_code  <= 2'b10;
              state     <= ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
`endif
          end
        end

        HOLD: begin
          // Both a flush and a handoff release the held instruction.
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        ERR: begin
          // Sticky until reset.
          fetch_err <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch: directed scenarios for each behaviour
// plus a randomized run against a transaction-level model (expected queue of
// instructions owed to decode, PC model advanced on handoff / redirected on
// flush). Timeout expectations follow INSTR_FETCH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        clr;
  logic        fetch_en;
  logic [31:0] pc_val;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic        fetch_err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .fetch_en    (fetch_en),
    .pc_val      (pc_val),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_load     (pc_load),
    .fetch_err   (fetch_err),
    .err_code    (err_code)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change
  // right after that and are stable at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory image: a fixed scramble of the address.
  function automatic logic [31:0] image(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Finish any outstanding request and handoff, then sit in IDLE.
  task automatic drain();
    fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
    repeat (4) tick();
    mem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clr = 1'b0; fetch_en = 1'b0; pc_val = 32'h0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got %b exp 0", pc_load); end
    checks++; if ({fetch_err, err_code} !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", {fetch_err, err_code}); end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    pc_val = 32'h0; fetch_en = 1'b1; instr_ready = 1'b1; flush = 1'b0;
    tick();  // IDLE sampled pc 0
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL zw_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr got %h exp 0", mem_addr); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL zw_load_req got %b exp 0", pc_load); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
    tick();  // ack in first REQ cycle
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== 32'h0000_0093) begin errors++; $display("FAIL zw_instr got %h exp 00000093", instr); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zw_req_drop got %b exp 0", mem_req); end
    #1;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL zw_load got %b exp 1", pc_load); end
    tick();  // handoff; PC advances
    pc_val = 32'h4;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_once got %b exp 0", instr_valid); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL zw_load_once got %b exp 0", pc_load); end
    checks++; if (instr !== 32'h0000_0093) begin errors++; $display("FAIL zw_instr_hold got %h exp 00000093", instr); end
    tick();  // IDLE sampled pc 4
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL zw_next_addr got %b/%h exp 1/00000004", mem_req, mem_addr); end
    drain();
  endtask

  task automatic test_wait_backpressure();
    pc_val = 32'h8; fetch_en = 1'b1; instr_ready = 1'b0;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL wb_req_c%0d got %b/%h exp 1/00000008", i, mem_req, mem_addr); end
      mem_ack = (i == 3); mem_rdata = 32'h1234_5013;
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wb_req_end got %b exp 0", mem_req); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5013) begin errors++; $display("FAIL wb_hold_c%0d got %b/%h exp 1/12345013", j, instr_valid, instr); end
      instr_ready = (j == 2);
      #1;
      checks++; if (pc_load !== (j == 2)) begin errors++; $display("FAIL wb_load_c%0d got %b exp %b", j, pc_load, (j == 2)); end
      tick();
    end
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wb_valid_end got %b exp 0", instr_valid); end
  endtask

  task automatic test_flush_req();
    pc_val = 32'h10; fetch_en = 1'b1; instr_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL fr_req_c%0d got %b/%h exp 1/00000010", i, mem_req, mem_addr); end
      flush = (i == 0); mem_ack = (i == 2); mem_rdata = 32'hAAAA_5555;
      #1;
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL fr_load_c%0d got %b exp 0", i, pc_load); end
      tick();
    end
    flush = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b0 || pc_load !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fr_dropped_c%0d got v%b l%b r%b exp 000", i, instr_valid, pc_load, mem_req); end
      tick();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_hold();
    pc_val = 32'h20; fetch_en = 1'b1; instr_ready = 1'b0;
    tick();
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0513;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fh_valid got %b exp 1", instr_valid); end
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL fh_load got %b exp 0", pc_load); end
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fh_valid_drop got %b exp 0", instr_valid); end
    // Back in IDLE: a flush blocks the start for one cycle only.
    pc_val = 32'h30; fetch_en = 1'b1; flush = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fi_blocked got %b exp 0", mem_req); end
    flush = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin errors++; $display("FAIL fi_start got %b/%h exp 1/00000030", mem_req, mem_addr); end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] pc_model, pc_drv_last, last_addr;
    logic        req_prev, drop_seen, exp_load;
    int          wait_cnt, handoffs;
    pc_model = 32'h100; pc_val = pc_model; req_prev = 1'b0; drop_seen = 1'b0;
    wait_cnt = 0; handoffs = 0; last_addr = 32'h0;
    fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      pc_drv_last = pc_val;
      pc_val = pc_model;
      if (mem_req && !req_prev) begin
        checks++; if (mem_addr !== pc_drv_last) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, mem_addr, pc_drv_last); end
        wait_cnt = $urandom_range(0, 3);
      end
      if (mem_req && req_prev) begin
        checks++; if (mem_addr !== last_addr) begin errors++; $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", cyc, mem_addr, last_addr); end
      end
      req_prev = mem_req;
      last_addr = mem_addr;
      fetch_en = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 11) == 0);
      instr_ready = 1'($urandom_range(0, 1));
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = image(mem_addr);
        end else begin
          wait_cnt--;
        end
      end
      #1;
      checks++; if (instr_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instr_valid, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        checks++; if (instr !== exp_q[0]) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", cyc, instr, exp_q[0]); end
      end
      exp_load = (exp_q.size() != 0) && instr_ready && !flush;
      checks++; if (pc_load !== exp_load) begin errors++; $display("FAIL rnd_pc_load cyc %0d got %b exp %b", cyc, pc_load, exp_load); end
      if (fetch_err !== 1'b0) begin
        checks++; errors++; $display("FAIL rnd_no_err cyc %0d got %b exp 0", cyc, fetch_err);
      end
      // Model update for the coming edge.
      if (exp_q.size() != 0 && (flush || instr_ready)) void'(exp_q.pop_front());
      if (exp_load) begin
        pc_model = pc_model + 32'h4;
        handoffs++;
      end
      if (flush) pc_model = 32'($urandom_range(0, 4095)) << 2;
      if (mem_req && mem_ack) begin
        if (!drop_seen && !flush) exp_q.push_back(image(mem_addr));
        drop_seen = 1'b0;
      end else if (mem_req && flush) begin
        drop_seen = 1'b1;
      end
    end
    checks++; if (handoffs < 10) begin errors++; $display("FAIL rnd_handoffs got %0d exp >=10", handoffs); end
    drain();
  endtask

  task automatic test_timeout();
    pc_val = 32'h40; fetch_en = 1'b1; instr_ready = 1'b0; mem_ack = 1'b0;
    tick();
    fetch_en = 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req_c%0d got %b exp 1", i, mem_req); end
      tick();
    end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b exp 0", mem_req); end
    checks++; if (fetch_err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL to_err got %b/%b exp 1/10", fetch_err, err_code); end
    clr = 1'b0;
    #1;
    clr = 1'b1;
    tick();
`else
    repeat (100) tick();
    checks++; if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL nto_req got %b/%b exp 1/0", mem_req, fetch_err); end
    drain();
`endif
  endtask

  task automatic test_misaligned();
    pc_val = 32'h6; fetch_en = 1'b1; instr_ready = 1'b0;
    tick();
    checks++; if (fetch_err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL mis_err got %b/%b exp 1/01", fetch_err, err_code); end
    pc_val = 32'h8;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("FAIL mis_stuck_c%0d got r%b e%b exp r0 e1", i, mem_req, fetch_err); end
      tick();
    end
    clr = 1'b0;
    #1;
    checks++; if ({mem_req, instr_valid, pc_load, fetch_err, err_code} !== 6'b0 || mem_addr !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL mis_clr got %b %h %h exp 000000 0 0", {mem_req, instr_valid, pc_load, fetch_err, err_code}, mem_addr, instr);
    end
    clr = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_zero_wait();
    test_wait_backpressure();
    test_flush_req();
    test_flush_hold();
    test_random();
    test_timeout();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RV32I core: the consumer of the program counter register. It samples the current PC value, issues a word read to instruction memory with a req/ack handshake, and holds the returned instruction for the decoder with a valid/ready handshake. On handoff it pulses the PC's load strobe so the PC advances. It sits between the PC register, instruction memory and the decode stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles `mem_req` may wait for `mem_ack`. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  permits a new fetch to start from IDLE.
- pc_val  in  32  current PC from the PC register.
- flush  in  1  branch/jump redirect; discards the in-flight or held instruction.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  32  word address, registered copy of `pc_val`.
- mem_ack  in  1  memory accepted the request and `mem_rdata` is valid this cycle.
- mem_rdata  in  32  instruction word.
- instr  out  32  held instruction to decode.
- instr_valid  out  1  `instr` is valid.
- instr_ready  in  1  decode accepts `instr`.
- pc_load  out  1  one-cycle strobe to the PC's `load` input; `inc` is held high by the top level.
- fetch_err  out  1  sticky error flag.
- err_code  out  2  error cause: 01 = misaligned PC, 10 = memory timeout.

## Operation
- The FSM has four states: IDLE, REQ, HOLD, ERR.
- **IDLE:**
  - If `fetch_en` is high and `flush` is low, sample `pc_val`.
  - If `pc_val[1:0]` is not 00, go to ERR and set `err_code` to 01. No request is issued.
  - Otherwise, register `mem_addr <= pc_val` and go to REQ.
- **REQ:**
  - `mem_req` is 1 and `mem_addr` is stable until ack.
  - When `mem_ack` is 1, latch `instr <= mem_rdata` and go to HOLD. If the drop flag is set, instead clear it, discard the data and go to IDLE.
- **Flush in REQ:** the bus transaction cannot be cancelled. Set the drop flag and keep `mem_req` high until ack.
- **HOLD:**
  - `instr_valid` is 1.
  - When `instr_ready` is 1, that cycle is the handoff. `pc_load` = `instr_valid & instr_ready & ~flush`, combinational. Go to IDLE.
- **Flush in HOLD:** clear `instr_valid`, go to IDLE, and do not assert `pc_load`. The branch path loads the PC itself.
- **Flush in IDLE:** blocks the fetch start for that cycle only.
- **ERR:** `fetch_err` is 1, with no requests. Only `clr` exits ERR.
- `instr` holds its value after handoff, but is meaningful only while `instr_valid` is high.

## Timing
- **Reset values** (while `clr` = 0): state IDLE; `mem_req` 0, `mem_addr` 0, `instr` 0, `instr_valid` 0, `pc_load` 0, `fetch_err` 0, `err_code` 00; drop flag 0; timeout counter 0.
- Reset asserted mid-operation drops everything immediately, including a pending memory ack.
- `mem_req` is asserted the cycle after IDLE samples a valid PC.
- An ack in the first REQ cycle is legal (zero-wait memory).
- Data is visible (`instr_valid` = 1) the cycle after ack.
- Minimum throughput is 3 cycles per instruction with zero-wait memory and `instr_ready` tied high: IDLE, REQ, HOLD.
- The PC updates on the handoff edge, so the next IDLE cycle sees PC+4.
- All outputs except `pc_load` are registered.
- **Flush and ack in the same REQ cycle:** the data is discarded and the next state is IDLE.
- **Flush and ready in the same HOLD cycle:** the flush wins. There is no handoff and no `pc_load`.

## Configuration
- **`INSTR_FETCH_TIMEOUT_EN` defined:**
  - A counter increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, deassert `mem_req`, go to ERR and set `err_code` to 10.
  - The counter clears on ack and on entry to REQ.
- **`INSTR_FETCH_TIMEOUT_EN` not defined:** there is no counter, REQ waits indefinitely, and `err_code` 10 is never produced.

## Test plan
- **Zero-wait fetch:** drive `pc_val` = 0x0000_0000, `fetch_en` = 1, `mem_ack` in the first REQ cycle, `mem_rdata` = 0x0000_0093, `instr_ready` = 1.
  - Expect `mem_addr` = 0 and `instr` = 0x0000_0093 with `instr_valid` for 1 cycle.
  - Expect `pc_load` to pulse once and the next `mem_addr` to be 0x4.
- **Wait states and backpressure:** ack after 3 cycles, `instr_ready` low for 2 cycles.
  - `mem_req` stays high for 4 cycles with `mem_addr` stable.
  - `instr_valid` is held for 3 cycles, and `pc_load` fires only in the ready cycle.
- **Flush in REQ:** assert `flush` in cycle 1 of REQ, then ack in cycle 3.
  - `mem_req` stays high until ack, the data is dropped, and `instr_valid` and `pc_load` never assert.
- **Flush together with `instr_ready` in HOLD:** `instr_valid` drops, `pc_load` stays 0, and the state returns to IDLE.
- **Misaligned PC:** drive `pc_val` = 0x0000_0006.
  - `mem_req` never asserts, `fetch_err` = 1 and `err_code` = 01.
  - Pulsing `clr` low returns all outputs to reset values.
- **Timeout** (macro defined, TIMEOUT_CYCLES = 4): no ack.
  - `mem_req` drops after 4 cycles, `fetch_err` = 1 and `err_code` = 10.
  - With the macro undefined, `mem_req` is still high after 100 cycles.
